// File: rtl/led_matrix_scan_if.sv
// Bundles the game-side write/swap signals and the matrix drive outputs of led_matrix_scan.
// Optional dim input is present only when LED_MATRIX_DIM_EN is defined.
interface led_matrix_scan_if;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_r;
    logic [7:0] wr_g;
    logic [7:0] wr_b;
    logic       swap_req;
    logic       swap_pending;
    logic       swap_done;
    logic       frame_start;
    logic [7:0] DATA_R;
    logic [7:0] DATA_G;
    logic [7:0] DATA_B;
    logic [2:0] COMM;
    logic       EN;
`ifdef LED_MATRIX_DIM_EN
    logic [1:0] dim;
`endif

    // No backpressure anywhere: a write is taken on every edge where wr_en=1, and a
    // swap_req pulse is latched into swap_pending, which stays high until swap_done.
    modport master (
`ifdef LED_MATRIX_DIM_EN
        output dim,
`endif
        output wr_en, wr_row, wr_r, wr_g, wr_b, swap_req,
        input  swap_pending, swap_done, frame_start,
        input  DATA_R, DATA_G, DATA_B, COMM, EN
    );

    modport slave (
`ifdef LED_MATRIX_DIM_EN
        input  dim,
`endif
        input  wr_en, wr_row, wr_r, wr_g, wr_b, swap_req,
        output swap_pending, swap_done, frame_start,
        output DATA_R, DATA_G, DATA_B, COMM, EN
    );
endinterface

// File: rtl/led_matrix_scan.sv
// Double-buffered 8x8 RGB LED row scanner with per-row blanking and frame-aligned swaps.
// Define LED_MATRIX_DIM_EN to add the 2-bit dim input that shortens each row's lit window.
module led_matrix_scan #(
    parameter int ROW_CYC   = 10000,
    parameter int BLANK_CYC = 16
) (
    input  logic             CLK,
    input  logic             rst_n,
    led_matrix_scan_if.slave bus
);
    localparam int            PW     = $clog2(ROW_CYC);
    localparam logic [PW-1:0] P_LAST = PW'(ROW_CYC - 1);
    localparam logic [PW-1:0] P_LOAD = PW'(BLANK_CYC - 1);

    logic [PW-1:0] p;
    logic [2:0]    row;
    logic          sel;
    logic [23:0]   mem [16];
    logic [23:0]   data_q;
    logic          wrap;
    logic          frame_end;
    logic          load_hit;
    logic          off_hit;

    assign wrap      = (p == P_LAST);
    assign frame_end = wrap && (row == 3'd7);
    assign load_hit  = (p == P_LOAD);

`ifdef LED_MATRIX_DIM_EN
    localparam int VIS = ROW_CYC - BLANK_CYC;
    logic [1:0] dim_q;
    int         win;

    // A zero-length window blanks on the same edge that would have loaded the row.
    always_comb begin
        win     = VIS >> dim_q;
        off_hit = ((BLANK_CYC + win) < ROW_CYC) && (int'(p) == (BLANK_CYC + win - 1));
    end
`else
    assign off_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            p                <= '0;
            row              <= 3'd0;
            sel              <= 1'b0;
            data_q           <= '1;
            bus.COMM         <= 3'd0;
            bus.EN           <= 1'b0;
            bus.swap_pending <= 1'b0;
            bus.swap_done    <= 1'b0;
            bus.frame_start  <= 1'b0;
`ifdef LED_MATRIX_DIM_EN
            dim_q            <= 2'd0;
`endif
            for (int i = 0; i < 16; i++) mem[i] <= '1;
        end else begin
            bus.EN          <= 1'b1;
            p               <= wrap ? '0 : p + PW'(1);
            bus.frame_start <= frame_end;
            bus.swap_done   <= frame_end && bus.swap_pending;

            if (frame_end && bus.swap_pending) begin
                sel              <= ~sel;
                bus.swap_pending <= 1'b0;
            end else if (bus.swap_req) begin
                bus.swap_pending <= 1'b1;
            end

            // Back bank uses the pre-toggle select, so a write on the swap edge lands in the new front.
            if (bus.wr_en) mem[{~sel, bus.wr_row}] <= {bus.wr_r, bus.wr_g, bus.wr_b};

            if (wrap) begin
                row      <= row + 3'd1;
                bus.COMM <= row + 3'd1;
                data_q   <= '1;
`ifdef LED_MATRIX_DIM_EN
                dim_q    <= bus.dim;
`endif
            end else if (off_hit) begin
                data_q <= '1;
            end else if (load_hit) begin
                data_q <= mem[{sel, row}];
            end
        end
    end

    assign bus.DATA_R = data_q[23:16];
    assign bus.DATA_G = data_q[15:8];
    assign bus.DATA_B = data_q[7:0];
endmodule
